systolic_feeder: RTL and testbench

Edge driver for the weight-stationary N×N MAC systolic array.
- Buffers one N×N weight tile and an M-row feature-map tile.
- Shifts the weights into the array's north edge (WM/WEn) and then streams skewed feature-map rows into the west edge (FM).
- Follows with a zero-drain window so every partial sum leaves the south edge, then pulses done.

---
 rtl/systolic_feeder.sv | 159 +++++++++++++++
 tb/tb_systolic_feeder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Edge driver for a weight-stationary NxN MAC systolic array: buffers a weight
// tile and a feature-map tile, shifts weights in from the north, streams skewed
// feature-map rows from the west, drains the array, then pulses done.
module systolic_feeder #(
  parameter int unsigned N  = 4,
  parameter int unsigned M  = 8,
  parameter int unsigned DW = 8,
  localparam int unsigned MAXNM = (N > M) ? N : M,
  localparam int unsigned AW    = (MAXNM > 1) ? $clog2(MAXNM) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_addr,
  input  logic [N*DW-1:0] wr_data,
  input  logic            start,
  output logic [N*DW-1:0] wm_south,
  output logic            wen,
  output logic [N*DW-1:0] fm_east,
  output logic            busy,
  output logic            done
);

  localparam int unsigned RW  = N * DW;
  localparam int unsigned WAW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FAW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW  = $clog2(M + N + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   wm_q, wm_d;
  logic [RW-1:0]   fm_q, fm_d;
  logic            wen_q, wen_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [RW-1:0]   wbuf [N];
  logic [RW-1:0]   fmbuf [M];

  logic            w_we, f_we;
  logic [WAW-1:0]  widx;

  // Buffer writes are only accepted in IDLE and only for in-range rows
  assign w_we = wr_en && (state_q == S_IDLE) && !wr_sel &&
                ({1'b0, wr_addr} < (AW+1)'(N));
  assign f_we = wr_en && (state_q == S_IDLE) && wr_sel &&
                ({1'b0, wr_addr} < (AW+1)'(M));

  // Tile buffers: plain RAM, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_we) wbuf[wr_addr[WAW-1:0]] <= wr_data;
    if (f_we) fmbuf[wr_addr[FAW-1:0]] <= wr_data;
  end

  // Next-state and per-state cycle counter; counter restarts on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          cnt_d   = '0;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STREAM: begin
        if (cnt_q == CW'(M + N - 2)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the upcoming cycle, derived from next state so the
  // registered outputs line up with the state they belong to
  always_comb begin
    wen_d  = (state_d == S_LOAD_W);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    wm_d   = '0;
    fm_d   = '0;
    widx   = WAW'(CW'(N - 1) - cnt_d);
    if (state_d == S_LOAD_W) begin
      // forward a same-cycle weight write so start+write sees the new row
      if (w_we && (wr_addr[WAW-1:0] == widx)) wm_d = wr_data;
      else                                    wm_d = wbuf[widx];
    end
    if (state_d == S_STREAM) begin
      for (int r = 0; r < int'(N); r++) begin
        if ((cnt_d >= CW'(r)) && ((cnt_d - CW'(r)) < CW'(M)))
          fm_d[r*DW +: DW] = fmbuf[FAW'(cnt_d - CW'(r))][r*DW +: DW];
      end
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wm_q    <= '0;
      fm_q    <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wm_q    <= wm_d;
      fm_q    <= fm_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wm_south = wm_q;
  assign fm_east  = fm_q;
  assign wen      = wen_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with N=4, M=8, DW=8.
module tb_systolic_feeder;

  localparam int unsigned N   = 4;
  localparam int unsigned M   = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 3;
  localparam int          RUN = 20;  // 4 load + 11 stream + 4 drain + 1 done
  localparam int          CAP = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en, wr_sel, start;
  logic [AW-1:0]   wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N*DW-1:0] wm_south, fm_east;
  logic            wen, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  systolic_feeder #(.N(N), .M(M), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .wm_south(wm_south), .wen(wen),
    .fm_east(fm_east), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic        wen;
    logic [31:0] wm;
    logic [31:0] fm;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        tbl [15];
  logic        cap_wen  [CAP];
  logic        cap_busy [CAP];
  logic        cap_done [CAP];
  logic [31:0] cap_wm   [CAP];
  logic [31:0] cap_fm   [CAP];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Start a run and capture CAP samples, c=0 being the first LOAD_W cycle
  task automatic do_run(input bit inject);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < CAP; c++) begin
      cap_wen[c] = wen; cap_busy[c] = busy; cap_done[c] = done;
      cap_wm[c] = wm_south; cap_fm[c] = fm_east;
      if (inject && c == 6) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd2; wr_data = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_run(input string tag);
    foreach (tbl[i]) begin
      int c;
      c = tbl[i].c;
      chk($sformatf("%s c%0d wen", tag, c), 32'(cap_wen[c]), 32'(tbl[i].wen));
      chk($sformatf("%s c%0d wm_south", tag, c), cap_wm[c], tbl[i].wm);
      chk($sformatf("%s c%0d fm_east", tag, c), cap_fm[c], tbl[i].fm);
      chk($sformatf("%s c%0d busy", tag, c), 32'(cap_busy[c]), 32'(tbl[i].busy));
      chk($sformatf("%s c%0d done", tag, c), 32'(cap_done[c]), 32'(tbl[i].done));
    end
    for (int c = 0; c < CAP; c++) begin
      chk($sformatf("%s seq c%0d busy", tag, c), 32'(cap_busy[c]), 32'(c < RUN));
      chk($sformatf("%s seq c%0d done", tag, c), 32'(cap_done[c]), 32'(c == RUN - 1));
      chk($sformatf("%s seq c%0d wen", tag, c), 32'(cap_wen[c]), 32'(c < 4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd;
    tbl[0]  = '{0,  1'b1, 32'h0F0E0D0C, 32'h0,        1'b1, 1'b0};
    tbl[1]  = '{1,  1'b1, 32'h0B0A0908, 32'h0,        1'b1, 1'b0};
    tbl[2]  = '{2,  1'b1, 32'h07060504, 32'h0,        1'b1, 1'b0};
    tbl[3]  = '{3,  1'b1, 32'h03020100, 32'h0,        1'b1, 1'b0};
    tbl[4]  = '{4,  1'b0, 32'h0,        32'h00000000, 1'b1, 1'b0};
    tbl[5]  = '{5,  1'b0, 32'h0,        32'h00000110, 1'b1, 1'b0};
    tbl[6]  = '{6,  1'b0, 32'h0,        32'h00021120, 1'b1, 1'b0};
    tbl[7]  = '{7,  1'b0, 32'h0,        32'h03122130, 1'b1, 1'b0};
    tbl[8]  = '{11, 1'b0, 32'h0,        32'h43526170, 1'b1, 1'b0};
    tbl[9]  = '{12, 1'b0, 32'h0,        32'h53627100, 1'b1, 1'b0};
    tbl[10] = '{14, 1'b0, 32'h0,        32'h73000000, 1'b1, 1'b0};
    tbl[11] = '{15, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[12] = '{18, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    tbl[13] = '{19, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
    tbl[14] = '{20, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset wen", 32'(wen), 32'h0);
    chk("reset wm_south", wm_south, 32'h0);
    chk("reset fm_east", fm_east, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++)
      wr(1'b0, AW'(i), {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)});
    for (int m = 0; m < 8; m++)
      wr(1'b1, AW'(m), {8'(16*m+3), 8'(16*m+2), 8'(16*m+1), 8'(16*m)});
    // out-of-range weight row must be dropped
    wr(1'b0, 3'd5, 32'hDEAD_BEEF);

    // run with start and a busy-time FM write injected mid-STREAM
    do_run(1'b1);
    check_run("run1");
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("no second run busy cycles", 32'(nb), 32'h0);

    // original FM row 2 and weights must be intact
    do_run(1'b0);
    check_run("run2");

    // start together with a weight write: the new row is seen immediately
    @(negedge clk);
    start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd3; wr_data = 32'hA5A5_A5A5;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    chk("start+write wen", 32'(wen), 32'h1);
    chk("start+write wm_south", wm_south, 32'hA5A5_A5A5);
    repeat (RUN) @(negedge clk);
    chk("start+write run over busy", 32'(busy), 32'h0);
    wr(1'b0, 3'd3, 32'h0F0E0D0C);

    // reset mid-STREAM at t=3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-abort fm_east t3", fm_east, 32'h03122130);
    #1 rst = 1'b1;
    #1;
    chk("abort wen", 32'(wen), 32'h0);
    chk("abort wm_south", wm_south, 32'h0);
    chk("abort fm_east", fm_east, 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nb = 0; nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    chk("post-abort busy cycles", 32'(nb), 32'h0);
    chk("post-abort done pulses", 32'(nd), 32'h0);

    do_run(1'b0);
    check_run("run3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
